// File: rtl/pwl_sched_pkg.sv
`timescale 1ns/1ps
// Shared types for the pwl adder scheduler: the pwl value, FSM states,
// the latched operation record and the pwl_add2 arithmetic.
package pwl_sched_pkg;

  typedef struct {
    real a;
    real b;
    real t0;
  } pwl;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Widest tag the op record carries; N_REQ tops out at 16.
  localparam int OP_ID_W = 4;

  typedef struct {
    pwl                 in1;
    pwl                 in2;
    real                s1;
    real                s2;
    logic [OP_ID_W-1:0] id;
  } sched_op_t;

  function automatic pwl pwl_zero();
    pwl z;
    z.a  = 0.0;
    z.b  = 0.0;
    z.t0 = 0.0;
    return z;
  endfunction

  // Scaled sum of two lines, re-anchored at time t.
  function automatic pwl pwl_add2_eval(input pwl in1, input pwl in2,
                                       input real s1, input real s2,
                                       input real t);
    pwl r;
    r.a  = s1 * (in1.a + in1.b * (t - in1.t0)) + s2 * (in2.a + in2.b * (t - in2.t0));
    r.b  = s1 * in1.b + s2 * in2.b;
    r.t0 = t;
    return r;
  endfunction

endpackage

// File: rtl/pwl_add_sched_add2.sv
`timescale 1ns/1ps
// Shared pwl adder. The sum is formed on the enabled clock edge so the
// result is anchored at that edge's time and then held until the next use.
module pwl_add2
  import pwl_sched_pkg::*;
(
  input  logic clk,
  input  logic rstb,
  input  logic enable,
  input  pwl   in1,
  input  pwl   in2,
  input  real  scale1,
  input  real  scale2,
  output pwl   out
);

  pwl out_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_q <= pwl_zero();
    end else if (enable) begin
      out_q <= pwl_add2_eval(in1, in2, scale1, scale2, $realtime);
    end
  end

  assign out = out_q;

endmodule

// File: rtl/pwl_add_sched_rr_arb.sv
`timescale 1ns/1ps
// Combinational round-robin arbiter: first set request strictly after
// 'last', wrapping modulo N_REQ.
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last) + k) % N_REQ);
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/pwl_add_sched.sv
`timescale 1ns/1ps
// Time-shares one pwl_add2 among N_REQ requesters: round-robin grant,
// per-requester scaling, and a tagged response held until consumed.
module pwl_add_sched
  import pwl_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  pwl                req_in1 [N_REQ],
  input  pwl                req_in2 [N_REQ],
  input  logic              cfg_we,
  input  logic [ID_W-1:0]   cfg_idx,
  input  real               cfg_scale1,
  input  real               cfg_scale2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output pwl                rsp_val,
  output logic              busy,
  output logic [15:0]       done_cnt,
  output sched_state_t      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high. req_ready is combinational from req_valid and state;
  // rsp_valid is registered and rsp_val/rsp_id hold until rsp_ready.

  sched_state_t    state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     done_cnt_q, done_cnt_d;
  sched_op_t       op_q, op_d;
  real             scale1_q [N_REQ];
  real             scale1_d [N_REQ];
  real             scale2_q [N_REQ];
  real             scale2_d [N_REQ];

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_vld;
  logic             add_en;

  rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (req_valid),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  pwl_add2 u_add (
    .clk    (clk),
    .rstb   (rstb),
    .enable (add_en),
    .in1    (op_q.in1),
    .in2    (op_q.in2),
    .scale1 (op_q.s1),
    .scale2 (op_q.s2),
    .out    (rsp_val)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    rsp_id_d   = rsp_id_q;
    done_cnt_d = done_cnt_q;
    op_d       = op_q;
    scale1_d   = scale1_q;
    scale2_d   = scale2_q;
    add_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          op_d.in1 = req_in1[gnt_id];
          op_d.in2 = req_in2[gnt_id];
          op_d.s1  = scale1_q[gnt_id];
          op_d.s2  = scale2_q[gnt_id];
          op_d.id  = OP_ID_W'(gnt_id);
          last_d   = gnt_id;
          state_d  = ADD;
        end
      end
      ADD: begin
        add_en   = 1'b1;
        rsp_id_d = op_q.id[ID_W-1:0];
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          done_cnt_d = done_cnt_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Scales were copied into op_d from the _q side above, so a write that
    // lands on the accept edge only affects later grants.
    if (cfg_we && (int'(cfg_idx) < N_REQ)) begin
      scale1_d[cfg_idx] = cfg_scale1;
      scale2_d[cfg_idx] = cfg_scale2;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      last_q     <= ID_W'(N_REQ - 1);
      rsp_id_q   <= '0;
      done_cnt_q <= '0;
      op_q.in1   <= pwl_zero();
      op_q.in2   <= pwl_zero();
      op_q.s1    <= 1.0;
      op_q.s2    <= 1.0;
      op_q.id    <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        scale1_q[i] <= 1.0;
        scale2_q[i] <= 1.0;
      end
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rsp_id_q   <= rsp_id_d;
      done_cnt_q <= done_cnt_d;
      op_q       <= op_d;
      scale1_q   <= scale1_d;
      scale2_q   <= scale2_d;
    end
  end

  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);
  assign done_cnt  = done_cnt_q;
  assign dbg_state = state_q;

endmodule
